// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the multicycle fetch/sequencing stage.
package fetch_ctrl_pkg;
   localparam int STAT_W = 4;
   localparam int DATA_W = 16;

   // Bit positions of each phase inside the one-hot stat vector.
   localparam int IF = 0;
   localparam int ID = 1;
   localparam int EX = 2;
   localparam int WB = 3;

   localparam logic [STAT_W-1:0] STAT_IDLE = 4'b0000;
   localparam logic [STAT_W-1:0] STAT_WB   = 4'b1000;

   localparam logic [3:0] OP_BNEQ = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   // State encoding is the stat vector itself, so stat needs no decode.
   typedef enum logic [STAT_W-1:0] {
      S_IDLE = 4'b0000,
      S_IF   = 4'b0001,
      S_ID   = 4'b0010,
      S_EX   = 4'b0100,
      S_WB   = 4'b1000
   } state_e;

   // Sign-extend an 8-bit branch offset to the PC width.
   function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
      return {{(DATA_W-8){v[7]}}, v};
   endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port. Handshake: the master holds imem_req and
// imem_addr steady until the cycle in which the slave raises imem_ack; that
// cycle transfers imem_rdata. imem_ack while imem_req is low is ignored.
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic              imem_req;
   logic [DATA_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl_stat_seq.sv
// Phase sequencer: IDLE -> IF (wait for ack) -> ID -> EX -> WB -> IF or IDLE.
module fetch_ctrl_stat_seq
   import fetch_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              ack,
   input  logic              halt,
   output logic [STAT_W-1:0] stat
);
   state_e state_q, state_d;

   // Next-phase selection; ack only matters in IF, halt only in WB.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_IF;
         S_IF:    if (ack) state_d = S_ID;
         S_ID:    state_d = S_EX;
         S_EX:    state_d = S_WB;
         S_WB:    state_d = halt ? S_IDLE : S_IF;
         default: state_d = S_IDLE;
      endcase
   end

   // Phase register; reset parks the stage in IDLE immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign stat = state_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: issues imem reads in IF, holds the instruction register,
// resolves BNEQ in EX and presents the PC offset to the PC adder in WB.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [STAT_W-1:0] stat,
   input  logic [DATA_W-1:0] inst_addr,
   fetch_ctrl_if.master      imem,
   output logic [DATA_W-1:0] inst,
   input  logic              eq_flag,
   output logic [DATA_W-1:0] imm_bneq,
   output logic              halted
);
   logic [DATA_W-1:0] inst_q, inst_d;
   logic              taken_q, taken_d;
   logic              halted_q, halted_d;
   logic              fetch_hit;
   logic              is_halt;
   logic              is_bneq;

   assign fetch_hit = stat[IF] && imem.imem_ack;
   assign is_halt   = (inst_q[15:12] == OP_HALT);
   assign is_bneq   = (inst_q[15:12] == OP_BNEQ);

   fetch_ctrl_stat_seq u_stat_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .ack   (imem.imem_ack),
      .halt  (is_halt),
      .stat  (stat)
   );

   // Next values for the instruction register, branch latch and halt flag.
   always_comb begin
      inst_d   = inst_q;
      taken_d  = taken_q;
      halted_d = halted_q;
      if (fetch_hit) inst_d = imem.imem_rdata;
      if (stat[EX])  taken_d = is_bneq && !eq_flag;
      if ((stat == STAT_IDLE) && start) halted_d = 1'b0;
      else if (stat[WB] && is_halt)     halted_d = 1'b1;
   end

   // Datapath state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q   <= '0;
         taken_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         inst_q   <= inst_d;
         taken_q  <= taken_d;
         halted_q <= halted_d;
      end
   end

   // Outputs decode only registered state, never imem_ack or eq_flag.
   assign imem.imem_req  = stat[IF];
   assign imem.imem_addr = stat[IF] ? inst_addr : '0;
   assign imm_bneq       = (stat[WB] && taken_q) ? sext8(inst_q[7:0]) : '0;
   assign inst           = inst_q;
   assign halted         = halted_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed plus randomized bench for fetch_ctrl with a PC-adder stand-in.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        eq_flag = 1'b0;
   logic [3:0]  stat;
   logic [15:0] inst;
   logic [15:0] imm_bneq;
   logic        halted;
   logic [15:0] pc_adder;

   fetch_ctrl_if imem ();

   fetch_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stat      (stat),
      .inst_addr (pc_adder),
      .imem      (imem),
      .inst      (inst),
      .eq_flag   (eq_flag),
      .imm_bneq  (imm_bneq),
      .halted    (halted)
   );

   // clock / reset
   always #5 clk = ~clk;

   // PC adder stand-in: updates at the edge ending WB.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pc_adder <= 16'h0000;
      else if (stat[3]) pc_adder <= pc_adder + 16'd1 + imm_bneq;
   end

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   logic [15:0] exp_pc = 16'h0000;
   logic [15:0] exp_inst = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // From IDLE at a negedge: pulse start and confirm the first IF cycle.
   task automatic do_start();
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check("start_stat", stat, 1);
      check("start_halted", halted, 0);
      check("start_addr", imem.imem_addr, exp_pc);
   endtask

   // One instruction through IF(+waits)/ID/EX/WB, entered at a negedge in IF.
   task automatic run_instr(input logic [15:0] word, input bit eq, input int waits, input bit noise);
      bit          hlt;
      bit          br;
      logic [15:0] off;
      hlt = (word[15:12] == 4'hF);
      br  = (word[15:12] == 4'hA) && !eq;
      off = br ? {{8{word[7]}}, word[7:0]} : 16'h0000;

      check("if_stat", stat, 1);
      check("if_req", imem.imem_req, 1);
      check("if_addr", imem.imem_addr, exp_pc);
      check("pc_value", pc_adder, exp_pc);
      check("if_halted", halted, 0);
      check("if_imm", imm_bneq, 0);
      for (int w = 0; w < waits; w++) begin
         imem.imem_ack   = 1'b0;
         imem.imem_rdata = 16'($urandom);
         start           = noise;
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         check("wait_stat", stat, 1);
         check("wait_addr", imem.imem_addr, exp_pc);
         check("wait_inst", inst, exp_inst);
      end
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = word;
      eq_flag         = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      imem.imem_ack = 1'b0;
      exp_inst      = word;
      check("id_stat", stat, 2);
      check("id_inst", inst, word);
      check("id_req", imem.imem_req, 0);
      check("id_addr", imem.imem_addr, 0);
      check("id_imm", imm_bneq, 0);

      if (noise) begin
         imem.imem_ack   = 1'b1;
         imem.imem_rdata = 16'($urandom);
      end
      @(posedge clk); @(negedge clk);
      imem.imem_ack = 1'b0;
      check("ex_stat", stat, 4);
      check("ex_inst", inst, word);
      check("ex_imm", imm_bneq, 0);

      eq_flag = eq;
      start   = noise;
      @(posedge clk); @(negedge clk);
      start   = 1'b0;
      eq_flag = 1'($urandom_range(0, 1));
      check("wb_stat", stat, 8);
      check("wb_imm", imm_bneq, off);
      check("wb_inst", inst, word);

      @(posedge clk); @(negedge clk);
      exp_pc = exp_pc + 16'd1 + off;
      if (hlt) begin
         check("halt_stat", stat, 0);
         check("halt_flag", halted, 1);
         check("halt_req", imem.imem_req, 0);
         check("halt_addr", imem.imem_addr, 0);
      end else begin
         check("next_stat", stat, 1);
      end
   endtask

   initial begin
      logic [3:0]  op;
      logic [15:0] w;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 16'h0000;

      // reset state
      @(negedge clk); @(negedge clk);
      check("rst_stat", stat, 0);
      check("rst_req", imem.imem_req, 0);
      check("rst_addr", imem.imem_addr, 0);
      check("rst_inst", inst, 0);
      check("rst_imm", imm_bneq, 0);
      check("rst_halted", halted, 0);
      rst_n = 1'b1;

      // ack in IDLE is ignored
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 16'h5A5A;
      @(posedge clk); @(negedge clk);
      imem.imem_ack = 1'b0;
      check("idle_ack_stat", stat, 0);
      check("idle_ack_inst", inst, 0);

      do_start();
      for (int i = 0; i < 5; i++) run_instr(16'h1000, 1'b0, 0, 1'b0);
      run_instr(16'h1000, 1'b0, 3, 1'b0);     // pc 5, three wait cycles
      run_instr(16'hA0FC, 1'b1, 0, 1'b1);     // pc 6, not taken
      run_instr(16'hF000, 1'b0, 0, 1'b0);     // pc 7, HALT

      // stay idle while halted
      imem.imem_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      imem.imem_ack = 1'b0;
      check("halt_idle_stat", stat, 0);
      check("halt_idle_inst", inst, 16'hF000);
      check("halt_idle_flag", halted, 1);

      do_start();
      check("restart_addr", imem.imem_addr, 16'h0008);
      run_instr(16'hA0FC, 1'b0, 0, 1'b1);     // pc 8, taken -> pc 5
      check("branch_target", imem.imem_addr, 16'h0005);
      run_instr(16'hA0FF, 1'b0, 1, 1'b0);     // self-loop at pc 5
      check("self_loop", imem.imem_addr, 16'h0005);

      // randomized instruction stream
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 14));
         if ($urandom_range(0, 2) == 0) op = 4'hA;
         w = {op, 12'($urandom)};
         run_instr(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // asynchronous reset in the middle of IF
      check("pre_rst_req", imem.imem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_req", imem.imem_req, 0);
      check("async_stat", stat, 0);
      check("async_addr", imem.imem_addr, 0);
      check("async_inst", inst, 0);
      check("async_halted", halted, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      exp_pc   = 16'h0000;
      exp_inst = 16'h0000;
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 16'h1234;
      @(posedge clk); @(negedge clk);
      imem.imem_ack = 1'b0;
      check("late_ack_stat", stat, 0);
      check("late_ack_inst", inst, 0);

      do_start();
      run_instr(16'h1000, 1'b0, 0, 1'b0);
      run_instr(16'hF0FF, 1'b0, 2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Multicycle fetch/sequencing stage that sits directly upstream of the PC adder. It generates the one-hot `stat` phase vector, issues instruction-memory reads at the address the PC adder presents during IF, and holds the instruction register. It evaluates BNEQ during EX and drives `imm_bneq` so the PC adder's WB-cycle update `pc <= pc+1+imm_bneq` performs either sequential advance or the branch.

## Interface
- `STAT_W`, 4 (from def.h): width of the phase vector.
- `DATA_W`, 16 (from def.h): instruction and address width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- `stat`  out  STAT_W  one-hot phase: bit `IF`=0, `ID`=1, `EX`=2, `WB`=3; all-zero = `STAT_IDLE`.
- `inst_addr`  in  16  fetch address from PC adder; valid only while `stat[IF]`.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  16  equals `inst_addr` while `imem_req`, else 16'h0000.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  16  instruction word, sampled when `imem_req && imem_ack`.
- `inst`  out  16  instruction register, for downstream decode/ALU.
- `eq_flag`  in  1  register-compare result from EX datapath, sampled at the end of EX.
- `imm_bneq`  out  16  PC offset; meaningful only in WB.
- `halted`  out  1  sticky, set by HALT, cleared by `start`.

## Operation
- States: IDLE, IF, ID, EX, WB; `stat` is a direct one-hot encoding (IDLE=4'b0000, WB=`STAT_WB`=4'b1000).
- IDLE: `start`=1 -> IF, clear `halted`.
- IF: `imem_req`=1. On `imem_ack`: load `inst` <= `imem_rdata`, -> ID. No ack: stay IF, `req` held, address stable.
- ID: one cycle -> EX.
- EX: one cycle; latch `taken` <= (`inst[15:12]`==4'hA, BNEQ) && !`eq_flag`; -> WB.
- WB: one cycle; `imm_bneq` = `taken` ? sign-extend(`inst[7:0]`) to 16 : 16'h0000. Next: HALT (`inst[15:12]`==4'hF) -> IDLE with `halted`=1; otherwise -> IF.
- `imm_bneq` forced to 0 in every state except WB.
- Offset arithmetic is 16-bit modulo; offset 8'hFF (-1) yields a self-loop, legal.
- `imem_ack` while `imem_req`=0 ignored; `start` while not IDLE ignored.
- HALT's WB still advances pc by 1; restart resumes at HALT+1.

## Timing
- Reset (async assert): `stat`=IDLE, `imem_req`=0, `imem_addr`=0, `inst`=16'h0000, `taken`=0, `imm_bneq`=0, `halted`=0. Reset mid-IF drops `imem_req` immediately; an in-flight ack after release is ignored (state is IDLE).
- `start` at edge N -> `stat[IF]` from cycle N+1.
- Zero-wait memory (ack in first IF cycle): 4 cycles/instruction IF,ID,EX,WB. Each wait cycle adds one IF cycle.
- `imem_req`, `imem_addr`, `stat`, `imm_bneq` are registered/state-decoded; no combinational path from `imem_ack` or `eq_flag` to any output.
- `imm_bneq` valid for the whole WB cycle; PC adder samples it at the edge ending WB.

## Structure
- def.h holds `STAT_W`, `DATA_W`, bit indices `IF/ID/EX/WB`, `STAT_IDLE`, `STAT_WB`, opcodes `OP_BNEQ`=4'hA, `OP_HALT`=4'hF.
- One sub-module: `stat_seq` (phase FSM: IDLE/IF/ID/EX/WB transitions, `start`/ack/halt inputs, one-hot `stat` out). IR, branch latch and `imm_bneq` formation stay in `fetch_ctrl`.

## Test plan
- Reset then `start`, memory acks every IF with 16'h1000 (non-branch) -> `stat` sequence 1,2,4,8 repeating, `imm_bneq`=0 in WB, PC adder pc 0,1,2,3.
- `imem_ack` delayed 3 cycles at pc=5 -> IF held 4 cycles, `imem_addr`=16'h0005 stable throughout, `inst` loads only on ack cycle.
- BNEQ 16'hA0FC with `eq_flag`=0 in EX -> `imm_bneq`=16'hFFFC in WB, next fetch address pc+1-4; same with `eq_flag`=1 -> `imm_bneq`=0.
- HALT 16'hF000 at pc=7 -> returns to IDLE, `halted`=1, `imem_req`=0; `start` -> `halted`=0, fetch at 16'h0008.
- Assert `rst_n`=0 during IF with `imem_req`=1 -> `imem_req` falls without clock edge; late ack after release leaves `inst`=0, state IDLE.
- `start` pulsed during EX and `imem_ack` pulsed in ID -> no state or `inst` change.
